// File: rtl/cam_pattern_gen.sv
// MT9V034-style parallel sensor emulator: PIXCLK = CLK/2, FRAME_VALID/LINE_VALID/DATA timing
// with programmable blanking and four selectable test patterns.
module cam_pattern_gen #(
  parameter int unsigned H        = 752,
  parameter int unsigned V        = 480,
  parameter int unsigned H_BLANK  = 94,
  parameter int unsigned V_BLANK  = 45,
  parameter int unsigned FV_LEAD  = 2,
  parameter int unsigned FV_TRAIL = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN,
  output logic       PIXCLK,
  output logic       FRAME_VALID,
  output logic       LINE_VALID,
  output logic [9:0] DATA,
  output logic [7:0] FRAME_COUNT,
  output logic       FRAME_DONE
);

  localparam int unsigned MaxA   = (H > H_BLANK) ? H : H_BLANK;
  localparam int unsigned MaxB   = (V_BLANK > FV_LEAD) ? V_BLANK : FV_LEAD;
  localparam int unsigned MaxC   = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntMax = (MaxC > FV_TRAIL) ? MaxC : FV_TRAIL;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned LineW  = $clog2(V + 1);

  localparam logic [CntW-1:0]  HLast     = CntW'(H - 1);
  localparam logic [CntW-1:0]  HBlkLast  = CntW'(H_BLANK - 1);
  localparam logic [CntW-1:0]  VBlkLast  = CntW'(V_BLANK - 1);
  localparam logic [CntW-1:0]  LeadLast  = CntW'(FV_LEAD - 1);
  localparam logic [CntW-1:0]  TrailLast = CntW'(FV_TRAIL - 1);
  localparam logic [LineW-1:0] LineLast  = LineW'(V - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StActive,
    StHblank,
    StTrail,
    StVblank
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [LineW-1:0] line_q;
  logic [1:0]       pat_q;
  logic             pixclk_q;
  logic             fv_q;
  logic             lv_q;
  logic [9:0]       data_q;
  logic [7:0]       fc_q;
  logic             done_q;

  function automatic logic [9:0] pixel(input logic [1:0] pat, input logic [9:0] col,
                                       input logic [9:0] line, input logic [7:0] fc);
    case (pat)
      2'd0:    return col;
      2'd1:    return line;
      2'd2:    return (col[3] ^ line[3]) ? 10'h3FF : 10'h000;
      default: return {fc, 2'b00};
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      line_q   <= '0;
      pat_q    <= '0;
      pixclk_q <= 1'b0;
      fv_q     <= 1'b0;
      lv_q     <= 1'b0;
      data_q   <= '0;
      fc_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      pixclk_q <= ~pixclk_q;
      done_q   <= 1'b0;
      // Tick: PIXCLK falls here, so outputs are settled by the next PIXCLK rise.
      if (pixclk_q) begin
        case (state_q)
          StIdle: begin
            if (ENABLE) begin
              pat_q   <= PATTERN;
              line_q  <= '0;
              cnt_q   <= '0;
              fv_q    <= 1'b1;
              state_q <= StLead;
            end
          end
          StLead: begin
            if (cnt_q == LeadLast) begin
              cnt_q   <= '0;
              lv_q    <= 1'b1;
              data_q  <= pixel(pat_q, 10'd0, 10'(line_q), fc_q);
              state_q <= StActive;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StActive: begin
            if (cnt_q == HLast) begin
              cnt_q  <= '0;
              lv_q   <= 1'b0;
              data_q <= '0;
              if (line_q != LineLast) begin
                line_q  <= line_q + 1'b1;
                state_q <= StHblank;
              end else begin
                state_q <= StTrail;
              end
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              data_q <= pixel(pat_q, 10'(cnt_q + 1'b1), 10'(line_q), fc_q);
            end
          end
          StHblank: begin
            if (cnt_q == HBlkLast) begin
              cnt_q   <= '0;
              lv_q    <= 1'b1;
              data_q  <= pixel(pat_q, 10'd0, 10'(line_q), fc_q);
              state_q <= StActive;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StTrail: begin
            if (cnt_q == TrailLast) begin
              cnt_q   <= '0;
              fv_q    <= 1'b0;
              done_q  <= 1'b1;
              fc_q    <= fc_q + 1'b1;
              state_q <= StVblank;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StVblank: begin
            if (cnt_q == VBlkLast) begin
              cnt_q <= '0;
              // Back-to-back frames skip IDLE so the low time is exactly V_BLANK periods.
              if (ENABLE) begin
                pat_q   <= PATTERN;
                line_q  <= '0;
                fv_q    <= 1'b1;
                state_q <= StLead;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            data_q  <= '0;
          end
        endcase
      end
    end
  end

  assign PIXCLK      = pixclk_q;
  assign FRAME_VALID = fv_q;
  assign LINE_VALID  = lv_q;
  assign DATA        = data_q;
  assign FRAME_COUNT = fc_q;
  assign FRAME_DONE  = done_q;

endmodule
